fft_bfly_pipe: RTL and testbench

Pipelined, parametrised radix-2 DIT butterfly with complex twiddle multiply and valid/ready flow control. It is the sequential successor of the fixed, twiddle-less column-0 butterfly. Each accepted operand pair (a, b, w) produces x = a + w*b and y = a - w*b. It is instanced per FFT column (stages 1..log2 N) and sits between the sample-memory readers and writers.

---
 rtl/fft_bfly_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_fft_bfly_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: three-stage radix-2 DIT butterfly, x = a + w*b, y = a - w*b,
// with valid/ready flow control and a sticky saturation flag.
//
// Optional build macro: BFLY_ROUND_EN (round-half-up in the twiddle product
// shift and in the scale-by-1/2 shift; truncation when undefined).
//
// Ports (all complex buses packed {re,im}):
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   in_valid/ready   operand beat handshake (in_ready is combinational)
//   in_a, in_b       operands, DATA_W-bit signed components
//   in_tw            twiddle, Q1.(TW_W-1) signed components
//   in_scale         1 = halve results, 0 = saturate at full scale
//   in_tag           sideband tag carried with the beat
//   out_valid/ready  result beat handshake
//   out_x, out_y     a + w*b, a - w*b
//   out_tag          tag of the result beat
//   ovf_sticky       any saturation since the last clear
//   ovf_clr          synchronous clear of ovf_sticky (a set wins)
module fft_bfly_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TW_W   = 16,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_a,
  input  logic [2*DATA_W-1:0] in_b,
  input  logic [2*TW_W-1:0]   in_tw,
  input  logic                in_scale,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_x,
  output logic [2*DATA_W-1:0] out_y,
  output logic [TAG_W-1:0]    out_tag,
  output logic                ovf_sticky,
  input  logic                ovf_clr
);

  localparam int unsigned CW = 2 * DATA_W;
  localparam int unsigned TC = 2 * TW_W;
  localparam int unsigned PW = DATA_W + TW_W + 1;
  localparam int unsigned SW = DATA_W + 2;

  // Add/sub one component, optionally halve, then saturate; returns {ovf, value}.
  function automatic logic [DATA_W:0] f_bfly(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W:0]   t,
    input logic                     scale,
    input logic                     sub
  );
    logic signed [SW-1:0] s;
    logic                 ovf;
    logic [DATA_W-1:0]    v;
    s = sub ? (SW'(a) - SW'(t)) : (SW'(a) + SW'(t));
    if (scale) begin
`ifdef BFLY_ROUND_EN
      s = s + SW'(1);
`endif
      s = s >>> 1;
    end
    // In range exactly when the bits above the DATA_W sign bit all match it.
    ovf = !((&s[SW-1:DATA_W-1]) || !(|s[SW-1:DATA_W-1]));
    if (ovf) begin
      v = s[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      v = s[DATA_W-1:0];
    end
    return {ovf, v};
  endfunction

  logic w_adv;

  logic               r_s1_valid;
  logic [CW-1:0]      r_s1_a;
  logic [CW-1:0]      r_s1_b;
  logic [TC-1:0]      r_s1_tw;
  logic               r_s1_scale;
  logic [TAG_W-1:0]   r_s1_tag;

  logic               r_s2_valid;
  logic signed [DATA_W:0] r_s2_tr;
  logic signed [DATA_W:0] r_s2_ti;
  logic [CW-1:0]      r_s2_a;
  logic               r_s2_scale;
  logic [TAG_W-1:0]   r_s2_tag;

  logic               r_s3_valid;
  logic               r_ovf;

  logic signed [DATA_W-1:0] w_br, w_bi;
  logic signed [TW_W-1:0]   w_wr, w_wi;
  logic signed [PW-1:0]     w_pr, w_pi;
  logic signed [PW-1:0]     w_pr_r, w_pi_r;
  logic signed [DATA_W:0]   w_tr, w_ti;
  logic [DATA_W:0]          w_xr, w_xi, w_yr, w_yi;
  logic                     w_ovf;

  // The whole pipeline moves together; bubbles are kept, not squeezed out.
  assign w_adv     = !r_s3_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_s3_valid;
  assign ovf_sticky = r_ovf;

  // S1: operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_tw    <= '0;
      r_s1_scale <= 1'b0;
      r_s1_tag   <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a     <= in_a;
        r_s1_b     <= in_b;
        r_s1_tw    <= in_tw;
        r_s1_scale <= in_scale;
        r_s1_tag   <= in_tag;
      end
    end
  end

  assign w_br = r_s1_b[CW-1:DATA_W];
  assign w_bi = r_s1_b[DATA_W-1:0];
  assign w_wr = r_s1_tw[TC-1:TW_W];
  assign w_wi = r_s1_tw[TW_W-1:0];

  // Complex product at full width, then drop the Q1 fraction bits.
  always_comb begin
    w_pr = PW'(w_br) * PW'(w_wr) - PW'(w_bi) * PW'(w_wi);
    w_pi = PW'(w_br) * PW'(w_wi) + PW'(w_bi) * PW'(w_wr);
`ifdef BFLY_ROUND_EN
    w_pr_r = w_pr + (PW'(1) <<< (TW_W - 2));
    w_pi_r = w_pi + (PW'(1) <<< (TW_W - 2));
`else
    w_pr_r = w_pr;
    w_pi_r = w_pi;
`endif
    w_tr = (DATA_W + 1)'(w_pr_r >>> (TW_W - 1));
    w_ti = (DATA_W + 1)'(w_pi_r >>> (TW_W - 1));
  end

  // S2: product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_tr    <= '0;
      r_s2_ti    <= '0;
      r_s2_a     <= '0;
      r_s2_scale <= 1'b0;
      r_s2_tag   <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_tr    <= w_tr;
        r_s2_ti    <= w_ti;
        r_s2_a     <= r_s1_a;
        r_s2_scale <= r_s1_scale;
        r_s2_tag   <= r_s1_tag;
      end
    end
  end

  assign w_xr = f_bfly(r_s2_a[CW-1:DATA_W], r_s2_tr, r_s2_scale, 1'b0);
  assign w_xi = f_bfly(r_s2_a[DATA_W-1:0],  r_s2_ti, r_s2_scale, 1'b0);
  assign w_yr = f_bfly(r_s2_a[CW-1:DATA_W], r_s2_tr, r_s2_scale, 1'b1);
  assign w_yi = f_bfly(r_s2_a[DATA_W-1:0],  r_s2_ti, r_s2_scale, 1'b1);
  assign w_ovf = w_xr[DATA_W] | w_xi[DATA_W] | w_yr[DATA_W] | w_yi[DATA_W];

  // S3: add/sub result, drives the output port directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_tag    <= '0;
    end else if (w_adv) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        out_x   <= {w_xr[DATA_W-1:0], w_xi[DATA_W-1:0]};
        out_y   <= {w_yr[DATA_W-1:0], w_yi[DATA_W-1:0]};
        out_tag <= r_s2_tag;
      end
    end
  end

  // Sticky overflow: a saturating beat entering S3 beats a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv && r_s2_valid && w_ovf) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// tb_fft_bfly_pipe: directed vectors with literal expectations plus a
// scoreboard fed by an arithmetic butterfly model, checked every cycle.
module tb_fft_bfly_pipe;

  localparam int DW  = 16;
  localparam int TW  = 16;
  localparam int TGW = 5;
  localparam longint SMAX = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (DW - 1));

  typedef struct {
    logic [2*DW-1:0] x;
    logic [2*DW-1:0] y;
    logic [TGW-1:0]  tag;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] in_a, in_b;
  logic [2*TW-1:0] in_tw;
  logic            in_scale;
  logic [TGW-1:0]  in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_x, out_y;
  logic [TGW-1:0]  out_tag;
  logic            ovf_sticky;
  logic            ovf_clr;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   ready_mode = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  fft_bfly_pipe #(.DATA_W(DW), .TW_W(TW), .TAG_W(TGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tw(in_tw), .in_scale(in_scale), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_tag(out_tag),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: plain integer arithmetic on the butterfly rules ----
  function automatic longint m_wrap(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint m_tw(input longint p);
    longint v;
    v = p;
`ifdef BFLY_ROUND_EN
    v = v + (longint'(1) <<< (TW - 2));
`endif
    return m_wrap(v >>> (TW - 1), DW + 1);
  endfunction

  function automatic longint m_out(input longint a, input longint t, input bit scale,
                                   input bit sub);
    longint s;
    s = sub ? a - t : a + t;
    if (scale) begin
`ifdef BFLY_ROUND_EN
      s = s + 1;
`endif
      s = s >>> 1;
    end
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
    return s;
  endfunction

  function automatic exp_t model(input logic [2*DW-1:0] a, input logic [2*DW-1:0] b,
                                 input logic [2*TW-1:0] w, input bit scale,
                                 input logic [TGW-1:0] tag);
    exp_t   e;
    longint ar, ai, br, bi, wr, wi, tr, ti;
    ar = $signed(a[2*DW-1:DW]); ai = $signed(a[DW-1:0]);
    br = $signed(b[2*DW-1:DW]); bi = $signed(b[DW-1:0]);
    wr = $signed(w[2*TW-1:TW]); wi = $signed(w[TW-1:0]);
    tr = m_tw(br * wr - bi * wi);
    ti = m_tw(br * wi + bi * wr);
    e.x   = {DW'(m_out(ar, tr, scale, 1'b0)), DW'(m_out(ai, ti, scale, 1'b0))};
    e.y   = {DW'(m_out(ar, tr, scale, 1'b1)), DW'(m_out(ai, ti, scale, 1'b1))};
    e.tag = tag;
    return e;
  endfunction

  // ---- out_ready driver: constant 1, or the 1,0,0,1 stall pattern ----
  int rdy_idx = 0;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) begin
      out_ready = 1'b1;
    end else begin
      out_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
      rdy_idx++;
    end
  end

  // ---- compare process: sampled mid-cycle, away from the active edge ----
  logic            hold = 1'b0;
  logic [2*DW-1:0] snap_x, snap_y;
  logic [TGW-1:0]  snap_tag;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      hold = 1'b0;
    end else begin
      chk("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
      if (hold) begin
        chk("stall out_valid", longint'(out_valid), 1);
        chk("stall out_x", longint'(out_x), longint'(snap_x));
        chk("stall out_y", longint'(out_y), longint'(snap_y));
        chk("stall out_tag", longint'(out_tag), longint'(snap_tag));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected beat: tag %0d with nothing outstanding", out_tag);
        end else begin
          e = q[0];
          chk("sb out_x", longint'(out_x), longint'(e.x));
          chk("sb out_y", longint'(out_y), longint'(e.y));
          chk("sb out_tag", longint'(out_tag), longint'(e.tag));
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      hold     = out_valid && !out_ready;
      snap_x   = out_x;
      snap_y   = out_y;
      snap_tag = out_tag;
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_tw, in_scale, in_tag));
    end
  end

  // ---- drivers ----
  task automatic send(input logic [2*DW-1:0] a, input logic [2*DW-1:0] b,
                      input logic [2*TW-1:0] w, input bit scale, input logic [TGW-1:0] tag);
    bit acc;
    int guard;
    guard = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_tw = w; in_scale = scale; in_tag = tag;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 50);
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL accept timeout: tag %0d never accepted", tag);
    end
    in_valid = 1'b0;
  endtask

  // Waits for out_valid; returns edges elapsed since send() returned.
  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!out_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL output timeout: out_valid=%0d after %0d cycles", out_valid, cycles);
    end
  endtask

  // Single beat on an idle pipe with out_ready=1; literal result check.
  // The beat is presented one edge before capture, so it is visible after the
  // third edge counted from presentation.
  task automatic single(input string name, input logic [2*DW-1:0] a,
                        input logic [2*DW-1:0] b, input logic [2*TW-1:0] w,
                        input bit scale, input logic [TGW-1:0] tag,
                        input longint xr, input longint xi,
                        input longint yr, input longint yi);
    int cyc;
    send(a, b, w, scale, tag);
    wait_out(cyc);
    chk({name, " latency"}, longint'(cyc + 1), 3);
    chk({name, " x.re"}, $signed(out_x[2*DW-1:DW]), xr);
    chk({name, " x.im"}, $signed(out_x[DW-1:0]), xi);
    chk({name, " y.re"}, $signed(out_y[2*DW-1:DW]), yr);
    chk({name, " y.im"}, $signed(out_y[DW-1:0]), yi);
    chk({name, " tag"}, longint'(out_tag), longint'(tag));
  endtask

  localparam longint R500 =
`ifdef BFLY_ROUND_EN
    500;
`else
    499;
`endif
  localparam longint ODD_RE =
`ifdef BFLY_ROUND_EN
    -1;
`else
    -2;
`endif
  localparam longint ODD_IM =
`ifdef BFLY_ROUND_EN
    2;
`else
    1;
`endif

  initial begin
    int cyc;
    int base;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tw = '0;
    in_scale = 1'b0; in_tag = '0; out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset out_x", longint'(out_x), 0);
    chk("reset out_y", longint'(out_y), 0);
    chk("reset out_tag", longint'(out_tag), 0);
    chk("reset ovf_sticky", longint'(ovf_sticky), 0);
    chk("reset in_ready", longint'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // a + (-1)*b and a - (-1)*b
    single("neg1", {16'd1000, 16'd0}, {16'd500, 16'd0}, {16'h8000, 16'h0000}, 1'b0, 5'd1,
           500, 0, 1500, 0);
    chk("neg1 ovf", longint'(ovf_sticky), 0);
    // w = -j, b = 300 - 200j
    single("minus_j", '0, {16'd300, 16'hFF38}, {16'h0000, 16'h8000}, 1'b0, 5'd2,
           -200, -300, 200, 300);
    // saturation on y, then clear
    single("sat", {16'd32000, 16'd0}, {16'd32000, 16'd0}, {16'h8000, 16'h0000}, 1'b0, 5'd3,
           0, 0, 32767, 0);
    chk("sat ovf", longint'(ovf_sticky), 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf clear", longint'(ovf_sticky), 0);
    single("sat_scaled", {16'd32000, 16'd0}, {16'd32000, 16'd0}, {16'h8000, 16'h0000},
           1'b1, 5'd4, 0, 0, 32000, 0);
    chk("sat_scaled ovf", longint'(ovf_sticky), 0);
    // +1 twiddle approximation
    single("plus1", '0, {16'd500, 16'd0}, {16'h7FFF, 16'h0000}, 1'b0, 5'd5,
           R500, 0, -R500, 0);
    // odd sum halved: -3 and 3
    single("odd_half", {16'hFFFD, 16'd3}, '0, '0, 1'b1, 5'd6,
           ODD_RE, ODD_IM, ODD_RE, ODD_IM);
    // negative saturation: y.re = -32000 - 31999
    single("neg_sat", {16'h8300, 16'd0}, {16'd32000, 16'd0}, {16'h7FFF, 16'h0000}, 1'b0,
           5'd7, -1, 0, -32768, 0);
    chk("neg_sat ovf", longint'(ovf_sticky), 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    chk("ovf clear 2", longint'(ovf_sticky), 0);
    // set and clear on the same edge: the set wins, the next edge clears
    single("set_wins", {16'd32000, 16'd0}, {16'd32000, 16'd0}, {16'h8000, 16'h0000}, 1'b0,
           5'd8, 0, 0, 32767, 0);
    chk("set wins", longint'(ovf_sticky), 1);
    @(posedge clk); #1;
    chk("clear after set", longint'(ovf_sticky), 0);
    ovf_clr = 1'b0;

    // stream 8 tagged beats against a stalling consumer
    base = n_out;
    ready_mode = 1;
    for (int i = 0; i < 8; i++) begin
      send({16'(i * 100), 16'(-i * 7)}, {16'(i * 50 + 3), 16'd11},
           {16'h5A82, 16'hA57E}, 1'(i % 2), 5'(i));
    end
    cyc = 0;
    while (q.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream delivered", longint'(n_out - base), 8);
    ready_mode = 0;
    @(posedge clk); #1;

    // reset with three beats in flight
    send({16'd1, 16'd2}, {16'd3, 16'd4}, {16'h4000, 16'h0000}, 1'b0, 5'd20);
    send({16'd5, 16'd6}, {16'd7, 16'd8}, {16'h4000, 16'h0000}, 1'b0, 5'd21);
    send({16'd9, 16'd10}, {16'd11, 16'd12}, {16'h4000, 16'h0000}, 1'b0, 5'd22);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", longint'(out_valid), 0);
    chk("midrst out_x", longint'(out_x), 0);
    chk("midrst out_y", longint'(out_y), 0);
    chk("midrst out_tag", longint'(out_tag), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset idle", longint'(out_valid), 0);
    single("after_rst", {16'd1000, 16'd0}, {16'd500, 16'd0}, {16'h8000, 16'h0000}, 1'b0,
           5'd9, 500, 0, 1500, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("queue drained", longint'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
